// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a host loader, CPU-first with a bounded host wait
module dmem_arbiter #(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_inchoice,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_outchoice,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic [1:0]  host_inchoice,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [2:0]  host_outchoice,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic [1:0]  dmem_inchoice,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_in,
  output logic [2:0]  dmem_outchoice,
  input  logic [31:0] dmem_out
);
  localparam logic [0:0] H_IDLE = 1'b0;
  localparam logic [0:0] H_ACK = 1'b1;
  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);
  logic [0:0] state;
  logic [3:0] wait_cnt;
  logic       host_elig;
  logic       host_gnt;
  logic       cpu_gnt;
  always_comb begin
    host_elig = rst_n & host_req & (state == H_IDLE);
    host_gnt = host_elig & (~cpu_req | (wait_cnt >= MAX_WAIT));
    cpu_gnt = rst_n & cpu_req & ~host_gnt;
    dmem_inchoice = host_gnt ? host_inchoice : cpu_gnt ? cpu_inchoice : 2'd0;
    dmem_addr = host_gnt ? host_addr : cpu_gnt ? cpu_addr : 32'd0;
    dmem_in = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : 32'd0;
    dmem_outchoice = host_gnt ? host_outchoice : cpu_gnt ? cpu_outchoice : 3'd0;
    cpu_rdata = cpu_gnt ? dmem_out : 32'd0;
    cpu_stall = cpu_req & ~cpu_gnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= H_IDLE;
      wait_cnt <= 4'd0;
      host_ack <= 1'b0;
      host_rdata <= 32'd0;
    end else begin
      state <= host_gnt ? H_ACK : H_IDLE;
      host_ack <= host_gnt;
      if (host_gnt) host_rdata <= dmem_out;
      wait_cnt <= host_gnt ? 4'd0 :
                  (host_elig & cpu_gnt & (wait_cnt < MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table plus randomized traffic checked against a cycle-level arbitration model
module tb_dmem_arbiter;
  localparam int MW = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [1:0]  cpu_inchoice;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_outchoice;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req;
  logic [1:0]  host_inchoice;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [2:0]  host_outchoice;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic [1:0]  dmem_inchoice;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_in;
  logic [2:0]  dmem_outchoice;
  logic [31:0] dmem_out;
  always #5 clk = ~clk;
  dmem_arbiter #(.HOST_MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_inchoice(cpu_inchoice), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_outchoice(cpu_outchoice), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_inchoice(host_inchoice), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_outchoice(host_outchoice), .host_ack(host_ack), .host_rdata(host_rdata),
    .dmem_inchoice(dmem_inchoice), .dmem_addr(dmem_addr), .dmem_in(dmem_in),
    .dmem_outchoice(dmem_outchoice), .dmem_out(dmem_out)
  );
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [1:0] ic, logic [1:0] a);
    logic [31:0] r;
    r = o;
    if (ic == 2'd1) r[8*int'(a) +: 8] = d[7:0];
    else if (ic == 2'd2) r[16*int'(a[1]) +: 16] = d[15:0];
    else if (ic == 2'd3) r = d;
    return r;
  endfunction
  logic [31:0] mem [64] = '{default: 32'd0};
  assign dmem_out = mem[dmem_addr[7:2]];
  always @(posedge clk)
    if (dmem_inchoice != 2'd0)
      mem[dmem_addr[7:2]] <= merge(mem[dmem_addr[7:2]], dmem_in, dmem_inchoice, dmem_addr[1:0]);
  typedef struct {
    bit rn, cr, hr, tab;
    logic [1:0] cic, hic;
    logic [31:0] ca, cw, ha, hw;
    logic [2:0] co, ho;
    bit e_stall, e_ack, e_hrv;
    logic [1:0] e_dic;
    logic [31:0] e_crd, e_hrd;
  } vec_t;
  function automatic vec_t mk(bit rn, bit cr, logic [1:0] cic, logic [31:0] ca, logic [31:0] cw,
                              bit hr, logic [1:0] hic, logic [31:0] ha, logic [31:0] hw,
                              bit es, bit ea, logic [1:0] edic, logic [31:0] ecrd, bit ehrv, logic [31:0] ehrd);
    vec_t v;
    v.rn = rn; v.cr = cr; v.cic = cic; v.ca = ca; v.cw = cw; v.co = 3'd2;
    v.hr = hr; v.hic = hic; v.ha = ha; v.hw = hw; v.ho = 3'd5; v.tab = 1'b1;
    v.e_stall = es; v.e_ack = ea; v.e_dic = edic; v.e_crd = ecrd; v.e_hrv = ehrv; v.e_hrd = ehrd;
    return v;
  endfunction
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  logic [31:0] rmem [64] = '{default: 32'd0};
  int          losses = 0;
  bit          last_hg = 1'b0;
  bit          exp_ack = 1'b0;
  bit          hr_known = 1'b1;
  bit          m_stall = 1'b0;
  logic [31:0] exp_hr = 32'd0;
  task automatic run(input vec_t v, input string tag);
    bit elig, hg, cg;
    logic [1:0] e_ic;
    logic [31:0] e_addr, e_in, e_crd;
    logic [2:0] e_oc;
    @(negedge clk);
    rst_n = v.rn;
    cpu_req = v.cr; cpu_inchoice = v.cic; cpu_addr = v.ca; cpu_wdata = v.cw; cpu_outchoice = v.co;
    host_req = v.hr; host_inchoice = v.hic; host_addr = v.ha; host_wdata = v.hw; host_outchoice = v.ho;
    #1;
    elig = v.rn && v.hr && !last_hg;
    hg = elig && (!v.cr || losses >= MW);
    cg = v.rn && v.cr && !hg;
    e_ic = hg ? v.hic : cg ? v.cic : 2'd0;
    e_addr = hg ? v.ha : cg ? v.ca : 32'd0;
    e_in = hg ? v.hw : cg ? v.cw : 32'd0;
    e_oc = hg ? v.ho : cg ? v.co : 3'd0;
    e_crd = cg ? rmem[v.ca[7:2]] : 32'd0;
    m_stall = v.cr && !cg;
    chk({tag, "_stall"}, cpu_stall, m_stall);
    chk({tag, "_cpu_rdata"}, cpu_rdata, e_crd);
    chk({tag, "_ack"}, host_ack, exp_ack);
    if (hr_known) chk({tag, "_host_rdata"}, host_rdata, exp_hr);
    chk({tag, "_dmem_inchoice"}, dmem_inchoice, e_ic);
    chk({tag, "_dmem_addr"}, dmem_addr, e_addr);
    chk({tag, "_dmem_in"}, dmem_in, e_in);
    chk({tag, "_dmem_outchoice"}, dmem_outchoice, e_oc);
    if (v.tab) begin
      chk({tag, "_tab_stall"}, cpu_stall, v.e_stall);
      chk({tag, "_tab_ack"}, host_ack, v.e_ack);
      chk({tag, "_tab_inchoice"}, dmem_inchoice, v.e_dic);
      chk({tag, "_tab_cpu_rdata"}, cpu_rdata, v.e_crd);
      if (v.e_hrv) chk({tag, "_tab_host_rdata"}, host_rdata, v.e_hrd);
    end
    @(posedge clk);
    if (!v.rn) begin
      losses = 0; last_hg = 1'b0; exp_ack = 1'b0; exp_hr = 32'd0; hr_known = 1'b1;
    end else begin
      if (hg) begin
        losses = 0;
        exp_hr = rmem[v.ha[7:2]];
        hr_known = (v.hic == 2'd0);
      end else if (elig && cg) losses++;
      exp_ack = hg;
      last_hg = hg;
      if ((hg || cg) && e_ic != 2'd0) rmem[e_addr[7:2]] = merge(rmem[e_addr[7:2]], e_in, e_ic, e_addr[1:0]);
    end
  endtask
  function automatic logic [31:0] raddr(logic [1:0] ic);
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if (ic == 2'd3) a[1:0] = 2'd0;
    else if (ic == 2'd2) a[0] = 1'b0;
    return a;
  endfunction
  vec_t vecs[$];
  vec_t rv;
  bit   h_busy = 1'b0;
  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    cpu_inchoice = 2'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_outchoice = 3'd0;
    host_inchoice = 2'd0; host_addr = 32'd0; host_wdata = 32'd0; host_outchoice = 3'd0;
    repeat (2) @(posedge clk);
    vecs.push_back(mk(0, 1, 3, 32'h44, 32'h22222222, 1, 3, 32'h40, 32'h11111111, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 32'h44, 32'h22222222, 1, 3, 32'h40, 32'h11111111, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 32'h20, 32'h12345678, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h12345678));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 0, 32'h10, 0, 1, 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'h12345678));
    vecs.push_back(mk(1, 1, 3, 32'h30, 32'hAAAA5555, 1, 0, 32'h10, 0, 1, 0, 0, 0, 1, 32'h12345678));
    vecs.push_back(mk(1, 1, 3, 32'h30, 32'hAAAA5555, 0, 0, 0, 0, 0, 1, 3, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA5555, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hAAAA5555));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF));
    foreach (vecs[i]) run(vecs[i], $sformatf("r%0d", i));
    rv = vecs[vecs.size()-1];
    rv.tab = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (h_busy && exp_ack) h_busy = 1'b0;
      if (!h_busy && $urandom_range(0, 1) == 1) begin
        h_busy = 1'b1;
        rv.hic = 2'($urandom_range(0, 3));
        rv.ha = raddr(rv.hic);
        rv.hw = $urandom;
        rv.ho = 3'($urandom_range(0, 7));
      end
      rv.hr = h_busy;
      if (!m_stall) begin
        rv.cr = ($urandom_range(0, 3) != 0);
        rv.cic = 2'($urandom_range(0, 3));
        rv.ca = raddr(rv.cic);
        rv.cw = $urandom;
        rv.co = 3'($urandom_range(0, 7));
      end
      rv.rn = ($urandom_range(0, 39) != 0);
      run(rv, "rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
